// File: rtl/tiny_core_gen2.sv
// tiny_core_gen2 -- small parametrised CPU core on a single shared memory bus.
// Fixed 16-bit instructions run one at a time through FETCH -> EXEC [-> MEM].
// Any bus cycle stretches for as long as ready is low.
// Level-sensitive interrupts are vectored and single-level; index 0 has the highest priority.
//
// Ports
//   clk           clock; all state changes on the rising edge
//   reset         asynchronous, active-high
//   address       bus address (pc during fetch, effective address during MEM)
//   data_in       read data; the instruction is data_in[15:0]
//   data_out      write data, driven while wr is high
//   rd / wr       read / write strobes, held until ready
//   ready         the bus completes the current access this cycle
//   irq           level interrupt requests
//   irq_ack       one-cycle pulse on interrupt entry; irq_id holds the accepted index
//   in_interrupt  a handler is active
//   hlt           halted until reset
//   wfi           waiting for an interrupt
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_FETCH | rd=1, address=pc; latch the instruction on ready
// S_EXEC  | execute, or compute the address of a memory access
// S_MEM   | hold rd/wr at maddr until ready, then write back
// S_WFI   | idle with no bus activity until any irq line is set
// S_HALT  | idle with no bus activity; only reset leaves this state

module tiny_core_gen2 #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 16,
    parameter int NREGS    = 4,
    parameter int IRQS     = 4,
    parameter int RESET_PC = 0,
    parameter int VEC_BASE = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] address,
    input  logic [WIDTH-1:0]  data_in,
    output logic [WIDTH-1:0]  data_out,
    output logic              rd,
    output logic              wr,
    input  logic              ready,
    input  logic [IRQS-1:0]   irq,
    output logic              irq_ack,
    output logic [2:0]        irq_id,
    output logic              in_interrupt,
    output logic              hlt,
    output logic              wfi
);

    localparam int RI_W = $clog2(NREGS);
    localparam logic [RI_W-1:0] SP_IDX = RI_W'(NREGS - 1);

    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WFI, S_HALT} state_t;

    state_t            state, state_nxt;
    logic              run;
    logic [ADDR_W-1:0] pc, pc_nxt, pc_inc, sh_pc, maddr, maddr_nxt, vec;
    logic [15:0]       instr;
    logic [WIDTH-1:0]  regs [NREGS];
    logic [WIDTH-1:0]  mdata, mdata_nxt;
    logic              mwrite, mwrite_nxt;
    logic              flag_c, flag_z, flag_n, c_nxt, z_nxt, n_nxt;
    logic              sh_c, sh_z, sh_n;
    logic              reg_we, reti, enter_fetch, take_irq, br_taken;
    logic [RI_W-1:0]   reg_wa, ra, rb;
    logic [WIDTH-1:0]  reg_wd, va, vb, sp, sx12, sx8, sx4, ea_ld, ea_st, sp_dec, sp_inc;
    logic [WIDTH-1:0]  alu_res;
    logic [WIDTH:0]    sum;
    logic              alu_c, alu_we, alu_fl;
    logic [3:0]        op, fn;
    logic [2:0]        irq_k;

    function automatic logic [RI_W-1:0] ridx(input logic [3:0] f);
        return RI_W'(int'(f) % NREGS);
    endfunction

    assign op     = instr[15:12];
    assign fn     = instr[3:0];
    assign ra     = ridx(instr[11:8]);
    assign rb     = ridx(instr[7:4]);
    assign va     = regs[ra];
    assign vb     = regs[rb];
    assign sp     = regs[SP_IDX];
    assign sx12   = {{(WIDTH-12){instr[11]}}, instr[11:0]};
    assign sx8    = {{(WIDTH-8){instr[7]}}, instr[7:0]};
    assign sx4    = {{(WIDTH-4){instr[3]}}, instr[3:0]};
    assign ea_ld  = vb + sx4;
    assign ea_st  = va + sx4;
    assign sp_dec = sp - WIDTH'(1);
    assign sp_inc = sp + WIDTH'(1);
    assign pc_inc = pc + ADDR_W'(1);
    // cond[3] inverts the sense; cond[2:0] selects which of c/z/n to test
    assign br_taken = (|(instr[10:8] & {flag_c, flag_z, flag_n})) ^ instr[11];
    assign hlt    = (state == S_HALT);
    assign wfi    = (state == S_WFI);

    always_comb begin
        alu_res = va;
        alu_c   = flag_c;
        alu_we  = 1'b0;
        alu_fl  = 1'b0;
        sum     = '0;
        case (fn)
            4'd0: begin
                sum = {1'b0, va} + {1'b0, vb};
                alu_res = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; alu_we = 1'b1; alu_fl = 1'b1;
            end
            4'd1, 4'd7: begin
                // bit WIDTH of the widened difference is the borrow
                sum = {1'b0, va} - {1'b0, vb};
                alu_res = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; alu_we = (fn == 4'd1); alu_fl = 1'b1;
            end
            4'd2: begin alu_res = va & vb; alu_we = 1'b1; alu_fl = 1'b1; end
            4'd3: begin alu_res = va | vb; alu_we = 1'b1; alu_fl = 1'b1; end
            4'd4: begin alu_res = va ^ vb; alu_we = 1'b1; alu_fl = 1'b1; end
            4'd5: begin alu_res = va << 1; alu_c = va[WIDTH-1]; alu_we = 1'b1; alu_fl = 1'b1; end
            4'd6: begin alu_res = va >> 1; alu_c = va[0]; alu_we = 1'b1; alu_fl = 1'b1; end
            4'd8: begin alu_res = va & vb; alu_fl = 1'b1; end
            4'd9: begin alu_res = vb; alu_we = 1'b1; alu_fl = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        irq_k = '0;
        for (int k = IRQS - 1; k >= 0; k--)
            if (irq[k]) irq_k = 3'(k);
    end
    assign vec = ADDR_W'(VEC_BASE) + ADDR_W'(irq_k);

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        c_nxt      = flag_c;
        z_nxt      = flag_z;
        n_nxt      = flag_n;
        reg_we     = 1'b0;
        reg_wa     = ra;
        reg_wd     = alu_res;
        maddr_nxt  = maddr;
        mdata_nxt  = mdata;
        mwrite_nxt = mwrite;
        reti       = 1'b0;
        rd         = 1'b0;
        wr         = 1'b0;
        address    = '0;
        data_out   = '0;
        case (state)
            S_FETCH: begin
                // run stays low until the first clock after reset so all outputs read 0 during reset
                if (run) begin
                    rd = 1'b1;
                    address = pc;
                    if (ready) state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                state_nxt = S_FETCH;
                pc_nxt    = pc_inc;
                case (op)
                    4'h0: pc_nxt = pc + sx12[ADDR_W-1:0];
                    4'h1: if (br_taken) pc_nxt = pc + sx8[ADDR_W-1:0];
                    4'h2: begin reg_we = 1'b1; reg_wd = sx8; end
                    4'h3: begin reg_we = 1'b1; reg_wd = (va << 8) | WIDTH'(instr[7:0]); end
                    4'h4: begin state_nxt = S_MEM; pc_nxt = pc; maddr_nxt = ea_ld[ADDR_W-1:0]; mwrite_nxt = 1'b0; end
                    4'h5: begin state_nxt = S_MEM; pc_nxt = pc; maddr_nxt = ea_st[ADDR_W-1:0]; mdata_nxt = vb; mwrite_nxt = 1'b1; end
                    4'h6: begin
                        reg_we = alu_we;
                        if (alu_fl) begin
                            c_nxt = alu_c;
                            z_nxt = (alu_res == '0);
                            n_nxt = alu_res[WIDTH-1];
                        end
                    end
                    4'h7: begin state_nxt = S_MEM; pc_nxt = pc; maddr_nxt = sp_dec[ADDR_W-1:0]; mdata_nxt = WIDTH'(pc_inc); mwrite_nxt = 1'b1; end
                    4'h8: begin state_nxt = S_MEM; pc_nxt = pc; maddr_nxt = sp[ADDR_W-1:0]; mwrite_nxt = 1'b0; end
                    4'h9: begin pc_nxt = sh_pc; c_nxt = sh_c; z_nxt = sh_z; n_nxt = sh_n; reti = 1'b1; end
                    4'hA: state_nxt = S_HALT;
                    4'hB: state_nxt = S_WFI;
                    default: ;
                endcase
            end
            S_MEM: begin
                rd       = ~mwrite;
                wr       = mwrite;
                address  = maddr;
                data_out = mwrite ? mdata : '0;
                if (ready) begin
                    state_nxt = S_FETCH;
                    pc_nxt    = pc_inc;
                    case (op)
                        4'h4: begin reg_we = 1'b1; reg_wd = data_in; end
                        4'h7: begin reg_we = 1'b1; reg_wa = SP_IDX; reg_wd = sp_dec; pc_nxt = pc + sx12[ADDR_W-1:0]; end
                        4'h8: begin reg_we = 1'b1; reg_wa = SP_IDX; reg_wd = sp_inc; pc_nxt = data_in[ADDR_W-1:0]; end
                        default: ;
                    endcase
                end
            end
            S_WFI: if (|irq) state_nxt = S_FETCH;
            default: ;
        endcase
    end

    // Interrupts are only sampled when the core is about to start a fresh fetch.
    assign enter_fetch = (state_nxt == S_FETCH) && (state != S_FETCH || !run);
    assign take_irq    = enter_fetch && !in_interrupt && (|irq);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run          <= 1'b0;
            pc           <= ADDR_W'(RESET_PC);
            instr        <= '0;
            flag_c       <= 1'b0;
            flag_z       <= 1'b0;
            flag_n       <= 1'b0;
            in_interrupt <= 1'b0;
            irq_ack      <= 1'b0;
            irq_id       <= '0;
            sh_pc        <= '0;
            sh_c         <= 1'b0;
            sh_z         <= 1'b0;
            sh_n         <= 1'b0;
            maddr        <= '0;
            mdata        <= '0;
            mwrite       <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            run    <= 1'b1;
            flag_c <= c_nxt;
            flag_z <= z_nxt;
            flag_n <= n_nxt;
            maddr  <= maddr_nxt;
            mdata  <= mdata_nxt;
            mwrite <= mwrite_nxt;
            if (reg_we) regs[reg_wa] <= reg_wd;
            if (state == S_FETCH && rd && ready) instr <= data_in[15:0];
            irq_ack <= take_irq;
            if (take_irq) begin
                // the shadow holds the state the interrupted code would have continued with
                sh_pc        <= pc_nxt;
                sh_c         <= c_nxt;
                sh_z         <= z_nxt;
                sh_n         <= n_nxt;
                pc           <= vec;
                in_interrupt <= 1'b1;
                irq_id       <= irq_k;
            end else begin
                pc <= pc_nxt;
                if (reti) in_interrupt <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tiny_core_gen2.sv
module tb_tiny_core_gen2;

    logic        clk = 1'b0;
    logic        reset16 = 1'b1, reset32 = 1'b1;
    logic [15:0] addr16, din16, dout16;
    logic        rd16, wr16, ready16 = 1'b1, irq_ack16, inint16, hlt16, wfi16;
    logic [3:0]  irq16 = '0;
    logic [2:0]  irq_id16;
    logic [15:0] addr32;
    logic [31:0] din32, dout32;
    logic        rd32, wr32, ready32 = 1'b1, irq_ack32, inint32, hlt32, wfi32;
    logic [3:0]  irq32 = '0;
    logic [2:0]  irq_id32;

    logic [15:0] mem16 [256];
    logic [31:0] mem32 [256];
    assign din16 = mem16[addr16[7:0]];
    assign din32 = mem32[addr32[7:0]];

    int checks = 0, errors = 0, cyc = 0;
    int fq[$], fc[$], fq32[$];
    int stall = 0, wr_hold = 0, both = 0, ack_cnt = 0, ack_addr = 0, ack_id = 0;
    logic ack_int;
    logic [15:0] w32_addr;
    logic [31:0] w32_data;

    always #5 clk = ~clk;

    tiny_core_gen2 dut16 (
        .clk(clk), .reset(reset16), .address(addr16), .data_in(din16), .data_out(dout16),
        .rd(rd16), .wr(wr16), .ready(ready16), .irq(irq16), .irq_ack(irq_ack16),
        .irq_id(irq_id16), .in_interrupt(inint16), .hlt(hlt16), .wfi(wfi16)
    );

    tiny_core_gen2 #(.WIDTH(32), .NREGS(8)) dut32 (
        .clk(clk), .reset(reset32), .address(addr32), .data_in(din32), .data_out(dout32),
        .rd(rd32), .wr(wr32), .ready(ready32), .irq(irq32), .irq_ack(irq_ack32),
        .irq_id(irq_id32), .in_interrupt(inint32), .hlt(hlt32), .wfi(wfi32)
    );

    // one cycle: sample at the falling edge, then answer the bus for the next rising edge
    task automatic step();
        @(negedge clk);
        cyc++;
        ready16 = 1'b1;
        if (wr16 && stall > 0) begin ready16 = 1'b0; stall--; end
        if (rd16 && wr16) both++;
        if (wr16 && addr16 == 16'h0012 && dout16 == 16'h7FFF) wr_hold++;
        if (rd16 && ready16) begin fq.push_back(int'(addr16)); fc.push_back(cyc); end
        if (wr16 && ready16) mem16[addr16[7:0]] = dout16;
        if (irq_ack16) begin ack_cnt++; ack_addr = int'(addr16); ack_id = int'(irq_id16); ack_int = inint16; end
        ready32 = 1'b1;
        if (rd32 && ready32) fq32.push_back(int'(addr32));
        if (wr32 && ready32) begin mem32[addr32[7:0]] = dout32; w32_addr = addr32; w32_data = dout32; end
    endtask

    task automatic clear16();
        for (int i = 0; i < 256; i++) mem16[i] = 16'hA000;
    endtask

    task automatic start16();
        reset16 = 1'b1; irq16 = '0;
        fq.delete(); fc.delete();
        both = 0; wr_hold = 0; ack_cnt = 0; ack_addr = 0; ack_id = 0;
        step();
        reset16 = 1'b0; stall = 0;
    endtask

    task automatic run_until_hlt16(input int max, input string name);
        int n = 0;
        while (!hlt16 && n < max) begin step(); n++; end
        checks++;
        if (hlt16 !== 1'b1) begin errors++; $display("FAIL %s: timeout, hlt=%b required 1", name, hlt16); end
    endtask

    function automatic bit seq_eq(input int a[$], input int b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic test_reset();
        clear16();
        reset16 = 1'b1;
        step(); step();
        checks++;
        if ({rd16, wr16, irq_ack16, hlt16, wfi16, inint16} !== 6'b0) begin
            errors++; $display("FAIL reset_outs: got %b required 000000", {rd16, wr16, irq_ack16, hlt16, wfi16, inint16});
        end
        checks++;
        if (addr16 !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h required 0000", addr16); end
        reset16 = 1'b0;
        step();
        checks++;
        if (rd16 !== 1'b1 || addr16 !== 16'h0000) begin
            errors++; $display("FAIL first_fetch: rd=%b addr=%h required rd=1 addr=0000", rd16, addr16);
        end
        #2 reset16 = 1'b1;
        #1;
        checks++;
        if (rd16 !== 1'b0 || hlt16 !== 1'b0) begin
            errors++; $display("FAIL async_drop: rd=%b hlt=%b required rd=0 hlt=0", rd16, hlt16);
        end
    endtask

    task automatic test_alu();
        clear16();
        mem16[0] = 16'h2105; mem16[1] = 16'h22FD; mem16[2] = 16'h6120; mem16[3] = 16'hA000;
        start16();
        run_until_hlt16(40, "alu_halt");
        checks++;
        if (dut16.regs[1] !== 16'h0002) begin errors++; $display("FAIL alu_r1: got %h required 0002", dut16.regs[1]); end
        checks++;
        if (dut16.regs[2] !== 16'hFFFD) begin errors++; $display("FAIL alu_r2: got %h required fffd", dut16.regs[2]); end
        checks++;
        if ({dut16.flag_c, dut16.flag_z, dut16.flag_n} !== 3'b100) begin
            errors++; $display("FAIL alu_flags: czn=%b required 100", {dut16.flag_c, dut16.flag_z, dut16.flag_n});
        end
        checks++;
        if (fc.size() < 4 || fc[1] - fc[0] != 2 || fc[2] - fc[1] != 2 || fc[3] - fc[2] != 2) begin
            errors++; $display("FAIL alu_latency: fetch cycles %p required spacing 2", fc);
        end
    endtask

    task automatic test_store();
        clear16();
        mem16[0] = 16'h2310; mem16[1] = 16'h207F; mem16[2] = 16'h30FF; mem16[3] = 16'h5302; mem16[4] = 16'hA000;
        start16();
        stall = 2;
        run_until_hlt16(40, "st_halt");
        checks++;
        if (wr_hold != 3) begin errors++; $display("FAIL st_hold: wr cycles at 0012/7fff %0d required 3", wr_hold); end
        checks++;
        if (mem16[8'h12] !== 16'h7FFF) begin errors++; $display("FAIL st_mem: got %h required 7fff", mem16[8'h12]); end
        checks++;
        if (both != 0) begin errors++; $display("FAIL st_strobes: rd&wr together %0d times required 0", both); end
        checks++;
        if (fc.size() < 5 || fc[4] - fc[3] != 5) begin
            errors++; $display("FAIL st_latency: fetch cycles %p required last gap 5", fc);
        end
    endtask

    task automatic test_branch();
        int exp[$] = '{0, 1, 2, 3, 7, 8};
        clear16();
        mem16[0] = 16'h2107; mem16[1] = 16'h2207; mem16[2] = 16'h6127; mem16[3] = 16'h1204;
        mem16[7] = 16'h1A10; mem16[8] = 16'hA000;
        start16();
        run_until_hlt16(40, "br_halt");
        checks++;
        if (!seq_eq(fq, exp)) begin errors++; $display("FAIL br_path: fetched %p required %p", fq, exp); end
        checks++;
        if (dut16.regs[1] !== 16'h0007) begin errors++; $display("FAIL cmp_r1: got %h required 0007", dut16.regs[1]); end
        checks++;
        if ({dut16.flag_c, dut16.flag_z, dut16.flag_n} !== 3'b010) begin
            errors++; $display("FAIL cmp_flags: czn=%b required 010", {dut16.flag_c, dut16.flag_z, dut16.flag_n});
        end
    endtask

    task automatic test_irq();
        int exp[$] = '{0, 8, 9, 10, 2, 32, 33, 34, 11};
        int n = 0;
        bit raised = 1'b0;
        clear16();
        mem16[0] = 16'h0008; mem16[2] = 16'h001E;
        mem16[32] = 16'h2355; mem16[33] = 16'h6337; mem16[34] = 16'h9000;
        mem16[8] = 16'h2105; mem16[9] = 16'h22FD; mem16[10] = 16'h6120; mem16[11] = 16'hA000;
        start16();
        while (!hlt16 && n < 60) begin
            step(); n++;
            if (!raised && fq.size() > 0 && fq[fq.size()-1] == 10) begin irq16 = 4'b0110; raised = 1'b1; end
            if (ack_cnt > 0) irq16 = '0;
        end
        checks++;
        if (hlt16 !== 1'b1) begin errors++; $display("FAIL irq_halt: timeout, hlt=%b required 1", hlt16); end
        checks++;
        if (ack_cnt != 1 || ack_id != 1 || ack_addr != 2) begin
            errors++; $display("FAIL irq_ack: count=%0d id=%0d addr=%0d required 1/1/2", ack_cnt, ack_id, ack_addr);
        end
        checks++;
        if (ack_int !== 1'b1) begin errors++; $display("FAIL irq_active: in_interrupt=%b at entry required 1", ack_int); end
        checks++;
        if (!seq_eq(fq, exp)) begin errors++; $display("FAIL irq_path: fetched %p required %p", fq, exp); end
        checks++;
        if ({dut16.flag_c, dut16.flag_z, dut16.flag_n} !== 3'b100 || inint16 !== 1'b0) begin
            errors++; $display("FAIL reti_restore: czn=%b in_int=%b required 100/0", {dut16.flag_c, dut16.flag_z, dut16.flag_n}, inint16);
        end
        checks++;
        if (dut16.regs[1] !== 16'h0002 || dut16.regs[3] !== 16'h0055) begin
            errors++; $display("FAIL irq_regs: r1=%h r3=%h required 0002/0055", dut16.regs[1], dut16.regs[3]);
        end
    endtask

    task automatic test_wfi();
        int n = 0;
        int bad = 0;
        clear16();
        mem16[0] = 16'h0008; mem16[4] = 16'h002C; mem16[48] = 16'h9000;
        mem16[8] = 16'hB000; mem16[9] = 16'hA000;
        start16();
        while (!wfi16 && n < 20) begin step(); n++; end
        checks++;
        if (wfi16 !== 1'b1) begin errors++; $display("FAIL wfi_enter: wfi=%b required 1", wfi16); end
        for (int i = 0; i < 10; i++) begin
            step();
            if (rd16 || wr16 || !wfi16) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL wfi_idle: %0d bad cycles required 0", bad); end
        irq16 = 4'b1000;
        n = 0;
        while (ack_cnt == 0 && n < 10) begin step(); n++; end
        irq16 = '0;
        checks++;
        if (ack_cnt != 1 || ack_id != 3 || ack_addr != 4) begin
            errors++; $display("FAIL wfi_wake: count=%0d id=%0d addr=%0d required 1/3/4", ack_cnt, ack_id, ack_addr);
        end
        run_until_hlt16(30, "wfi_halt");
        checks++;
        if (fq.size() == 0 || fq[fq.size()-1] != 9 || inint16 !== 1'b0) begin
            errors++; $display("FAIL wfi_return: fetched %p in_int=%b required last 9, in_int 0", fq, inint16);
        end
        irq16 = 4'b0001;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rd16 || wr16 || irq_ack16 || !hlt16) bad++;
        end
        irq16 = '0;
        checks++;
        if (bad != 0 || ack_cnt != 1) begin
            errors++; $display("FAIL halt_irq: %0d bad cycles, acks=%0d required 0/1", bad, ack_cnt);
        end
    endtask

    task automatic test_call32();
        int exp[$] = '{0, 1, 17, 63, 2, 63, 3};
        int n = 0;
        for (int i = 0; i < 256; i++) mem32[i] = 32'h0000A000;
        mem32[0] = 32'h2740; mem32[1] = 32'h7010; mem32[17] = 32'h8000;
        mem32[2] = 32'h417F; mem32[3] = 32'hA000;
        fq32.delete();
        w32_addr = '0; w32_data = '0;
        reset32 = 1'b1;
        step();
        reset32 = 1'b0;
        while (!hlt32 && n < 60) begin step(); n++; end
        checks++;
        if (hlt32 !== 1'b1) begin errors++; $display("FAIL call_halt: timeout, hlt=%b required 1", hlt32); end
        checks++;
        if (w32_addr !== 16'h003F || w32_data !== 32'h2 || mem32[63] !== 32'h2) begin
            errors++; $display("FAIL call_push: addr=%h data=%h mem=%h required 003f/2/2", w32_addr, w32_data, mem32[63]);
        end
        checks++;
        if (dut32.regs[7] !== 32'h40) begin errors++; $display("FAIL ret_sp: got %h required 40", dut32.regs[7]); end
        checks++;
        if (dut32.regs[1] !== 32'h2) begin errors++; $display("FAIL ld_r1: got %h required 2", dut32.regs[1]); end
        checks++;
        if (!seq_eq(fq32, exp)) begin errors++; $display("FAIL call_path: reads %p required %p", fq32, exp); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store();
        test_branch();
        test_irq();
        test_wfi();
        test_call32();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
